ahb3lite_cmd_master: RTL and testbench

AHB3LITE_CMD_MASTER -- requirements
Module: ahb3lite_cmd_master

---
 rtl/ahb3lite_cmd_master_if.sv | 25 ++
 rtl/ahb3lite_cmd_master.sv | 160 ++++++++++++++++
 tb/tb_ahb3lite_cmd_master.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb3lite_cmd_master_if.sv
// AHB3-lite master/slave signal bundle for ahb3lite_cmd_master; the master modport drives
// the address/control/write-data group and the slave modport drives HREADY/HRESP/HRDATA.
interface ahb3lite_cmd_master_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb3lite_cmd_master.sv
// Single-outstanding AHB3-lite command master: accept->rsp in 3 cycles min, cmd_ready only when idle.
// Optional data-phase timeout abort under `AHB3LITE_CMD_MASTER_TIMEOUT_EN (TIMEOUT_CYCLES HREADY-low cycles).
module ahb3lite_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    ahb3lite_cmd_master_if.master ahb
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t      r_state;
    logic        r_cmd_ready;
    logic [1:0]  r_htrans;
    logic [31:0] r_haddr;
    logic        r_hwrite;
    logic [2:0]  r_hsize;
    logic [31:0] r_hwdata;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic        w_accept;
    logic        w_cmd_ok;

`ifdef AHB3LITE_CMD_MASTER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_rsp_timeout;

    assign rsp_timeout = r_rsp_timeout;
`else
    assign rsp_timeout = 1'b0;
`endif

    // Misaligned or oversized commands are rejected locally without touching the bus.
    always_comb begin
        w_cmd_ok = 1'b0;
        case (cmd_size)
            3'd0:    w_cmd_ok = 1'b1;
            3'd1:    w_cmd_ok = (cmd_addr[0] == 1'b0);
            3'd2:    w_cmd_ok = (cmd_addr[1:0] == 2'b00);
            default: w_cmd_ok = 1'b0;
        endcase
    end

    assign w_accept = cmd_valid & r_cmd_ready;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_htrans    <= HTRANS_IDLE;
            r_haddr     <= '0;
            r_hwrite    <= 1'b0;
            r_hsize     <= '0;
            r_hwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef AHB3LITE_CMD_MASTER_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_rsp_timeout <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Ready drops during the response pulse because that cycle is spent here too.
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        if (w_cmd_ok) begin
                            r_state  <= ST_ADDR;
                            r_htrans <= HTRANS_NONSEQ;
                            r_haddr  <= cmd_addr;
                            r_hsize  <= cmd_size;
                            r_hwrite <= cmd_write;
                            r_hwdata <= cmd_wdata;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= 1'b1;
`ifdef AHB3LITE_CMD_MASTER_TIMEOUT_EN
                            r_rsp_timeout <= 1'b0;
`endif
                        end
                    end
                end
                ST_ADDR: begin
                    if (ahb.HREADY) begin
                        r_state  <= ST_DATA;
                        r_htrans <= HTRANS_IDLE;
`ifdef AHB3LITE_CMD_MASTER_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end
                end
                ST_DATA: begin
                    if (ahb.HREADY) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_hwrite ? 32'h0 : ahb.HRDATA;
                        r_rsp_err   <= ahb.HRESP;
`ifdef AHB3LITE_CMD_MASTER_TIMEOUT_EN
                        r_rsp_timeout <= 1'b0;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_state       <= ST_IDLE;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
`endif
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_htrans <= HTRANS_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_err       = r_rsp_err;

    assign ahb.HADDR     = r_haddr;
    assign ahb.HTRANS    = r_htrans;
    assign ahb.HWRITE    = r_hwrite;
    assign ahb.HSIZE     = r_hsize;
    assign ahb.HBURST    = 3'b000;
    assign ahb.HPROT     = 4'b0011;
    assign ahb.HMASTLOCK = 1'b0;
    assign ahb.HWDATA    = r_hwdata;

endmodule

// File: tb/tb_ahb3lite_cmd_master.sv
// Directed bench for ahb3lite_cmd_master: hand-stepped AHB slave responses, cycle-exact checks.
module tb_ahb3lite_cmd_master;

    localparam int unsigned TO = 8;

    logic        CLK;
    logic        RESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    int n_checks = 0;
    int n_errors = 0;

    ahb3lite_cmd_master_if ahb ();

    ahb3lite_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_size    (cmd_size),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .ahb         (ahb)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Returns in cycle N+1, just after the accepting edge.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] wd);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (cmd_ready !== 1'b1) chk("cmd_ready_wait", {31'b0, cmd_ready}, 32'h1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_size  = sz;
        cmd_wdata = wd;
        step();
        cmd_valid = 1'b0;
        cmd_addr  = 32'hDEAD_BEEF;
        cmd_wdata = 32'hFFFF_FFFF;
    endtask

    initial begin
        int pulses;
        RESETn     = 1'b1;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_size   = '0;
        cmd_wdata  = '0;
        ahb.HREADY = 1'b1;
        ahb.HRESP  = 1'b0;
        ahb.HRDATA = '0;

        // Reset values
        #1 RESETn = 1'b0;
        #1;
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        chk("rst_htrans", {30'b0, ahb.HTRANS}, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_timeout", {31'b0, rsp_timeout}, 32'h0);
        @(negedge CLK) RESETn = 1'b1;
        step();
        chk("rel_cmd_ready", {31'b0, cmd_ready}, 32'h1);
        chk("const_hburst", {29'b0, ahb.HBURST}, 32'h0);
        chk("const_hprot", {28'b0, ahb.HPROT}, 32'h3);
        chk("const_hmastlock", {31'b0, ahb.HMASTLOCK}, 32'h0);

        // Zero-wait word read
        ahb.HRDATA = 32'hCAFE_BABE;
        issue(1'b0, 32'h2000_0010, 3'd2, 32'h0);
        chk("rd_n1_htrans", {30'b0, ahb.HTRANS}, 32'h2);
        chk("rd_n1_haddr", ahb.HADDR, 32'h2000_0010);
        chk("rd_n1_hsize", {29'b0, ahb.HSIZE}, 32'h2);
        chk("rd_n1_hwrite", {31'b0, ahb.HWRITE}, 32'h0);
        chk("rd_n1_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        step();
        chk("rd_n2_htrans", {30'b0, ahb.HTRANS}, 32'h0);
        chk("rd_n2_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        step();
        chk("rd_n3_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("rd_n3_rdata", rsp_rdata, 32'hCAFE_BABE);
        chk("rd_n3_err", {31'b0, rsp_err}, 32'h0);
        chk("rd_n3_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        ahb.HRDATA = 32'h1111_2222;
        step();
        chk("rd_n4_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rd_n4_rdata_hold", rsp_rdata, 32'hCAFE_BABE);
        chk("rd_n4_cmd_ready", {31'b0, cmd_ready}, 32'h1);

        // Word write, 3 wait states
        issue(1'b1, 32'h4000_0004, 3'd2, 32'h1234_5678);
        chk("wr_n1_htrans", {30'b0, ahb.HTRANS}, 32'h2);
        chk("wr_n1_hwrite", {31'b0, ahb.HWRITE}, 32'h1);
        chk("wr_n1_haddr", ahb.HADDR, 32'h4000_0004);
        step();
        for (int i = 0; i < 4; i++) begin
            ahb.HREADY = (i == 3);
            chk($sformatf("wr_d%0d_hwdata", i), ahb.HWDATA, 32'h1234_5678);
            chk($sformatf("wr_d%0d_htrans", i), {30'b0, ahb.HTRANS}, 32'h0);
            chk($sformatf("wr_d%0d_rsp_valid", i), {31'b0, rsp_valid}, 32'h0);
            step();
        end
        chk("wr_n6_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("wr_n6_err", {31'b0, rsp_err}, 32'h0);
        chk("wr_n6_rdata", rsp_rdata, 32'h0);

        // Read with extended address phase, 1 wait state, two-cycle ERROR
        issue(1'b0, 32'h3000_0008, 3'd2, 32'h0);
        ahb.HREADY = 1'b0;
        chk("er_n1_htrans", {30'b0, ahb.HTRANS}, 32'h2);
        step();
        chk("er_n2_htrans_hold", {30'b0, ahb.HTRANS}, 32'h2);
        chk("er_n2_haddr_hold", ahb.HADDR, 32'h3000_0008);
        ahb.HREADY = 1'b1;
        step();
        chk("er_n3_htrans", {30'b0, ahb.HTRANS}, 32'h0);
        ahb.HREADY = 1'b0;
        ahb.HRESP  = 1'b0;
        step();
        chk("er_n4_htrans", {30'b0, ahb.HTRANS}, 32'h0);
        ahb.HRESP  = 1'b1;
        step();
        chk("er_n5_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("er_n5_htrans", {30'b0, ahb.HTRANS}, 32'h0);
        ahb.HREADY = 1'b1;
        step();
        chk("er_n6_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("er_n6_err", {31'b0, rsp_err}, 32'h1);
        ahb.HRESP = 1'b0;

        // Locally rejected commands
        issue(1'b0, 32'h0000_1001, 3'd2, 32'h0);
        chk("mis_n1_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("mis_n1_err", {31'b0, rsp_err}, 32'h1);
        chk("mis_n1_htrans", {30'b0, ahb.HTRANS}, 32'h0);
        chk("mis_n1_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        step();
        chk("mis_n2_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("mis_n2_err_hold", {31'b0, rsp_err}, 32'h1);
        chk("mis_n2_cmd_ready", {31'b0, cmd_ready}, 32'h1);
        issue(1'b1, 32'h0000_0100, 3'd3, 32'h0);
        chk("sz3_n1_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("sz3_n1_err", {31'b0, rsp_err}, 32'h1);
        chk("sz3_n1_htrans", {30'b0, ahb.HTRANS}, 32'h0);
        issue(1'b0, 32'h0000_0203, 3'd1, 32'h0);
        chk("hmis_n1_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("hmis_n1_err", {31'b0, rsp_err}, 32'h1);

        // Aligned halfword read goes to the bus
        ahb.HRDATA = 32'h5555_AAAA;
        issue(1'b0, 32'h4000_0002, 3'd1, 32'h0);
        chk("hw_n1_htrans", {30'b0, ahb.HTRANS}, 32'h2);
        chk("hw_n1_hsize", {29'b0, ahb.HSIZE}, 32'h1);
        step();
        step();
        chk("hw_n3_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("hw_n3_rdata", rsp_rdata, 32'h5555_AAAA);
        chk("hw_n3_err", {31'b0, rsp_err}, 32'h0);

`ifdef AHB3LITE_CMD_MASTER_TIMEOUT_EN
        // Timeout abort after TO data-phase cycles
        issue(1'b0, 32'h2000_0000, 3'd2, 32'h0);
        step();
        ahb.HREADY = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            step();
            chk($sformatf("to_wait%0d_rsp_valid", i), {31'b0, rsp_valid}, 32'h0);
        end
        step();
        chk("to_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("to_rsp_err", {31'b0, rsp_err}, 32'h1);
        chk("to_rsp_timeout", {31'b0, rsp_timeout}, 32'h1);
        step();
        chk("to_cmd_ready_after", {31'b0, cmd_ready}, 32'h1);
        ahb.HREADY = 1'b1;
        // Park a write in its data phase for the reset test
        issue(1'b1, 32'h6000_0040, 3'd2, 32'hA5A5_A5A5);
        step();
        ahb.HREADY = 1'b0;
        step();
`else
        // Without the timeout the data phase waits indefinitely
        issue(1'b1, 32'h6000_0040, 3'd2, 32'hA5A5_A5A5);
        step();
        ahb.HREADY = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rsp_valid === 1'b1) pulses++;
        end
        chk("nto_pulses", pulses, 32'h0);
        chk("nto_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        chk("nto_rsp_timeout", {31'b0, rsp_timeout}, 32'h0);
`endif

        // Asynchronous reset in the middle of the data phase
        chk("prerst_hwdata", ahb.HWDATA, 32'hA5A5_A5A5);
        RESETn = 1'b0;
        #1;
        chk("mrst_htrans", {30'b0, ahb.HTRANS}, 32'h0);
        chk("mrst_haddr", ahb.HADDR, 32'h0);
        chk("mrst_hwrite", {31'b0, ahb.HWRITE}, 32'h0);
        chk("mrst_hsize", {29'b0, ahb.HSIZE}, 32'h0);
        chk("mrst_hwdata", ahb.HWDATA, 32'h0);
        chk("mrst_rdata", rsp_rdata, 32'h0);
        chk("mrst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        chk("mrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        ahb.HREADY = 1'b1;
        @(negedge CLK) RESETn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rsp_valid === 1'b1) pulses++;
        end
        chk("mrst_no_pulse", pulses, 32'h0);
        chk("mrst_cmd_ready_after", {31'b0, cmd_ready}, 32'h1);

        ahb.HRDATA = 32'h0BAD_F00D;
        issue(1'b0, 32'h2000_0020, 3'd2, 32'h0);
        chk("post_n1_htrans", {30'b0, ahb.HTRANS}, 32'h2);
        step();
        step();
        chk("post_n3_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("post_n3_rdata", rsp_rdata, 32'h0BAD_F00D);
        chk("post_n3_err", {31'b0, rsp_err}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
